// File: rtl/uart_receiver_if.sv
// Reader-side handshake between the UART receiver and memory-mapped I/O.
// The receiver drives the held byte and its status flags. The reader returns read_ack.
interface uart_receiver_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       read_ack;

  modport master (
    output rx_byte,
    output rx_valid,
    output frame_err,
    output overrun,
    input  read_ack
  );

  modport slave (
    input  rx_byte,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output read_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// A one-entry holding register is read through a valid/ack handshake.
module uart_receiver #(
  parameter int unsigned BAUD_CLK_CYCLES = 10416,
  parameter int unsigned HALF_CYCLES     = BAUD_CLK_CYCLES / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_i,
  output logic           busy_o,
  uart_receiver_if.master bus
);

  localparam int unsigned CntW = $clog2(BAUD_CLK_CYCLES);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_CYCLES - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_CLK_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic            rx_s1_q, rx_s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    deliver = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s2_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          if (!rx_s2_q) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          deliver = 1'b1;
          state_d = rx_s2_q ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (rx_s2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An ack in the delivery cycle frees the slot, so the new byte is taken, not dropped.
    if (deliver) begin
      if (!valid_q || bus.read_ack) begin
        byte_d  = shift_q;
        valid_d = 1'b1;
        ferr_d  = !rx_s2_q;
        ovr_d   = 1'b0;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (bus.read_ack && valid_q) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign bus.rx_byte   = byte_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at B=16, H=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_receiver;
  localparam int B = 16;
  localparam int H = 8;
  // rx drops at negedge n0; rx_valid is first visible at negedge n0 + 1 + 2 + H + 9*B.
  localparam int Lat = 1 + 2 + H + 9 * B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_err = 0;
  int   rise;

  uart_receiver_if bus ();

  uart_receiver #(
    .BAUD_CLK_CYCLES(B),
    .HALF_CYCLES    (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx),
    .busy_o(busy),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_byte"}, {24'd0, bus.rx_byte}, 32'h00);
    check_eq({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check_eq({tag, "_ferr"}, {31'd0, bus.frame_err}, 32'd0);
    check_eq({tag, "_ovr"}, {31'd0, bus.overrun}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_ack();
    bus.read_ack = 1'b1;
    @(negedge clk);
    bus.read_ack = 1'b0;
  endtask

  // Called at a negedge. Sends one frame. rise_o is the loop index at which rx_valid was
  // first seen high (-1 if never). ack_at pulses read_ack at that index. abort_at resets
  // the DUT mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int ack_at,
                            input int abort_at, output int rise_o);
    int b;
    rise_o = -1;
    for (int i = 0; i < 10 * B; i++) begin
      b = i / B;
      if (b == 0)      rx = 1'b0;
      else if (b == 9) rx = stop;
      else             rx = data[b-1];
      if (ack_at >= 0) bus.read_ack = (i == ack_at);
      if (rise_o < 0 && bus.rx_valid === 1'b1) rise_o = i;
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bus.read_ack = 1'b0;
  endtask

  initial begin
    bus.read_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_rst");

    // 0xA5, good stop bit, no ack
    send_frame(8'hA5, 1'b1, -1, -1, rise);
    check_eq("a5_latency", rise, Lat);
    check_eq("a5_byte", {24'd0, bus.rx_byte}, 32'hA5);
    check_eq("a5_valid", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("a5_ferr", {31'd0, bus.frame_err}, 32'd0);
    check_eq("a5_ovr", {31'd0, bus.overrun}, 32'd0);
    check_eq("a5_busy", {31'd0, busy}, 32'd0);
    pulse_ack();
    check_eq("a5_ack_valid", {31'd0, bus.rx_valid}, 32'd0);

    // False start: 5-cycle low glitch
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check_eq("glitch_valid", {31'd0, bus.rx_valid}, 32'd0);

    // 0x3C with bad stop bit, line held low
    send_frame(8'h3C, 1'b0, -1, -1, rise);
    repeat (40) @(negedge clk);
    check_eq("3c_byte", {24'd0, bus.rx_byte}, 32'h3C);
    check_eq("3c_ferr", {31'd0, bus.frame_err}, 32'd1);
    check_eq("3c_valid", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("3c_wait_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("3c_idle_busy", {31'd0, busy}, 32'd0);
    pulse_ack();
    check_eq("3c_ack_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("3c_ack_ferr", {31'd0, bus.frame_err}, 32'd0);

    // Overrun: two frames back to back, no ack
    repeat (4) @(negedge clk);
    send_frame(8'h11, 1'b1, -1, -1, rise);
    send_frame(8'h22, 1'b1, -1, -1, rise);
    repeat (4) @(negedge clk);
    check_eq("ovr_byte", {24'd0, bus.rx_byte}, 32'h11);
    check_eq("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    check_eq("ovr_valid", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("ovr_ferr", {31'd0, bus.frame_err}, 32'd0);
    pulse_ack();
    check_eq("ovr_ack_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_eq("ovr_ack_flag", {31'd0, bus.overrun}, 32'd0);
    check_eq("ovr_ack_ferr", {31'd0, bus.frame_err}, 32'd0);

    // Ack coinciding with the stop sample of the second byte
    repeat (4) @(negedge clk);
    send_frame(8'h11, 1'b1, -1, -1, rise);
    send_frame(8'h22, 1'b1, Lat - 1, -1, rise);
    repeat (2) @(negedge clk);
    check_eq("samecyc_byte", {24'd0, bus.rx_byte}, 32'h22);
    check_eq("samecyc_valid", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("samecyc_ovr", {31'd0, bus.overrun}, 32'd0);

    // Reset in the middle of bit 4 while a byte is held
    send_frame(8'hFF, 1'b1, -1, 5 * B + B / 2, rise);
    repeat (4) @(negedge clk);
    check_reset_outputs("post_rst");
    send_frame(8'h5A, 1'b1, -1, -1, rise);
    check_eq("5a_latency", rise, Lat);
    check_eq("5a_byte", {24'd0, bus.rx_byte}, 32'h5A);
    check_eq("5a_valid", {31'd0, bus.rx_valid}, 32'd1);
    check_eq("5a_ferr", {31'd0, bus.frame_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
